machine_cmd_queue: RTL and testbench

- Buffers tagged machine commands ahead of the combinational step engine; sits directly upstream of it.
- Each entry is one 63-bit current-state word: {tag[2:0], a[29:0], b[29:0]}.
- The step engine's register stage pulls one word per accepted handshake.
- Illegal tags are filtered and counted here, so the step engine only sees tags 000..100.

---
 rtl/machine_cmd_queue.sv | 114 +++++++++++
 tb/tb_machine_cmd_queue.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/machine_cmd_queue.sv
// Command FIFO ahead of the step engine: stores legal-tag {tag, a, b} words
// and drops illegal tags, counting them in a saturating reject counter.
module machine_cmd_queue #(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic          system1000,
  input  logic          system1000_rstn,
  input  logic          flush,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_tag,
  input  logic [29:0]   cmd_a,
  input  logic [29:0]   cmd_b,
  output logic          issue_valid,
  input  logic          issue_ready,
  output logic [62:0]   issue_cmd,
  output logic [AW:0]   level,
  output logic [15:0]   reject_cnt,
  output logic          reject_pulse
);

  localparam logic [AW:0] FullLevel = (AW+1)'(DEPTH);
  localparam logic [AW:0] OneLevel  = (AW+1)'(1);

  typedef enum logic [1:0] {StEmpty, StActive, StFull} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     level_q, level_d;
  logic [15:0]     reject_cnt_q, reject_cnt_d;
  logic            reject_pulse_q, reject_pulse_d;
  logic [62:0]     mem [DEPTH];

  logic push, pop, legal, push_legal, wr_en;

  assign cmd_ready   = (state_q != StFull);
  assign issue_valid = (state_q != StEmpty);
  assign push        = cmd_valid & cmd_ready;
  assign pop         = issue_valid & issue_ready;
  assign legal       = (cmd_tag <= 3'b100);
  assign push_legal  = push & legal;

  always_comb begin
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    level_d        = level_q;
    reject_cnt_d   = reject_cnt_q;
    reject_pulse_d = 1'b0;
    wr_en          = 1'b0;
    if (flush) begin
      // Handshakes in a flush cycle complete but leave no trace.
      state_d  = StEmpty;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push & ~legal) begin
        reject_pulse_d = 1'b1;
        if (reject_cnt_q != 16'hFFFF) reject_cnt_d = reject_cnt_q + 16'd1;
      end
      if (push_legal) begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_legal, pop})
        2'b10:   level_d = level_q + OneLevel;
        2'b01:   level_d = level_q - OneLevel;
        default: level_d = level_q;
      endcase
      unique case (state_q)
        StEmpty:  if (push_legal) state_d = StActive;
        StActive: begin
          if (push_legal && !pop && level_q == FullLevel - OneLevel) state_d = StFull;
          else if (pop && !push_legal && level_q == OneLevel)       state_d = StEmpty;
        end
        StFull:   if (pop) state_d = StActive;
        default:  state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      state_q        <= StEmpty;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      level_q        <= '0;
      reject_cnt_q   <= '0;
      reject_pulse_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      level_q        <= level_d;
      reject_cnt_q   <= reject_cnt_d;
      reject_pulse_q <= reject_pulse_d;
    end
  end

  // Storage is not reset; only entries below level are ever visible.
  always_ff @(posedge system1000) begin
    if (wr_en) mem[wr_ptr_q] <= {cmd_tag, cmd_a, cmd_b};
  end

  assign issue_cmd    = issue_valid ? mem[rd_ptr_q] : '0;
  assign level        = level_q;
  assign reject_cnt   = reject_cnt_q;
  assign reject_pulse = reject_pulse_q;

endmodule

// File: tb/tb_machine_cmd_queue.sv
// Scoreboard bench for machine_cmd_queue (DEPTH=8): expected words are queued
// on accepted legal pushes and compared against issue_cmd when popped.
module tb_machine_cmd_queue;

  localparam int unsigned DEPTH = 8;

  logic        system1000 = 1'b0;
  logic        system1000_rstn;
  logic        flush, cmd_valid, cmd_ready, issue_valid, issue_ready, reject_pulse;
  logic [2:0]  cmd_tag;
  logic [29:0] cmd_a, cmd_b;
  logic [62:0] issue_cmd;
  logic [3:0]  level;
  logic [15:0] reject_cnt;

  machine_cmd_queue #(.DEPTH(DEPTH)) dut (
    .system1000      (system1000),
    .system1000_rstn (system1000_rstn),
    .flush           (flush),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_tag         (cmd_tag),
    .cmd_a           (cmd_a),
    .cmd_b           (cmd_b),
    .issue_valid     (issue_valid),
    .issue_ready     (issue_ready),
    .issue_cmd       (issue_cmd),
    .level           (level),
    .reject_cnt      (reject_cnt),
    .reject_pulse    (reject_pulse)
  );

  always #5 system1000 = ~system1000;

  logic [62:0] sb [$];
  logic [15:0] exp_rej;
  logic        exp_pulse;
  int          n_cmp = 0;
  int          n_fail = 0;

  // Drives one cycle from a negedge; the model decides push/pop from its own
  // occupancy. Returns the head word seen during a pop cycle.
  task automatic cyc(input logic v, input logic [2:0] tag, input logic [29:0] a,
                     input logic [29:0] b, input logic rdy, input logic fl,
                     output logic popped, output logic [62:0] word);
    logic mpush;
    cmd_valid = v; cmd_tag = tag; cmd_a = a; cmd_b = b; issue_ready = rdy; flush = fl;
    #1;
    popped = rdy && (sb.size() != 0) && !fl;
    word   = issue_cmd;
    mpush  = v && (sb.size() != DEPTH) && !fl;
    exp_pulse = 1'b0;
    if (mpush && tag > 3'b100) begin
      exp_pulse = 1'b1;
      if (exp_rej != 16'hFFFF) exp_rej = exp_rej + 16'd1;
    end
    if (fl) sb.delete();
    else if (mpush && tag <= 3'b100) sb.push_back({tag, a, b});
    @(negedge system1000);
    cmd_valid = 1'b0; issue_ready = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++; if (level !== 4'd0) begin n_fail++; $display("FAIL reset_level got %0d exp 0", level); end
    n_cmp++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", issue_valid); end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", cmd_ready); end
    n_cmp++; if (issue_cmd !== 63'd0) begin n_fail++; $display("FAIL reset_cmd got %h exp 0", issue_cmd); end
    n_cmp++; if (reject_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_rejcnt got %h exp 0", reject_cnt); end
    n_cmp++; if (reject_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_pulse got %b exp 0", reject_pulse); end
  endtask

  task automatic test_single();
    logic p; logic [62:0] w, e;
    cyc(1'b1, 3'b011, 30'd5, 30'd7, 1'b0, 1'b0, p, w);
    n_cmp++; if (issue_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b exp 1", issue_valid); end
    n_cmp++; if (issue_cmd !== {3'b011, 30'd5, 30'd7}) begin
      n_fail++; $display("FAIL single_cmd got %h exp %h", issue_cmd, {3'b011, 30'd5, 30'd7}); end
    n_cmp++; if (level !== 4'd1) begin n_fail++; $display("FAIL single_level got %0d exp 1", level); end
    cyc(1'b0, 3'b000, 30'd0, 30'd0, 1'b1, 1'b0, p, w);
    if (p) begin
      e = sb.pop_front();
      n_cmp++; if (w !== e) begin n_fail++; $display("FAIL single_pop got %h exp %h", w, e); end
    end
    n_cmp++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL single_empty got %b exp 0", issue_valid); end
    n_cmp++; if (level !== 4'd0) begin n_fail++; $display("FAIL single_level0 got %0d exp 0", level); end
  endtask

  task automatic test_fill_wrap();
    logic p; logic [62:0] w, e;
    for (int i = 0; i < 8; i++) cyc(1'b1, 3'b001, 30'(i), 30'(i + 50), 1'b0, 1'b0, p, w);
    n_cmp++; if (level !== 4'd8) begin n_fail++; $display("FAIL full_level got %0d exp 8", level); end
    n_cmp++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got %b exp 0", cmd_ready); end
    cyc(1'b1, 3'b001, 30'd99, 30'd99, 1'b0, 1'b0, p, w);
    n_cmp++; if (level !== 4'd8) begin n_fail++; $display("FAIL full_noaccept got %0d exp 8", level); end
    cyc(1'b0, 3'b000, 30'd0, 30'd0, 1'b1, 1'b0, p, w);
    if (p) begin
      e = sb.pop_front();
      n_cmp++; if (w !== e) begin n_fail++; $display("FAIL full_pop got %h exp %h", w, e); end
    end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL full_reready got %b exp 1", cmd_ready); end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 3'b100, 30'(i + 8), 30'(i + 58), 1'b1, 1'b0, p, w);
      if (p) begin
        e = sb.pop_front();
        n_cmp++; if (w !== e) begin n_fail++; $display("FAIL wrap_pop got %h exp %h", w, e); end
      end
    end
    for (int k = 0; k < 12 && sb.size() != 0; k++) begin
      cyc(1'b0, 3'b000, 30'd0, 30'd0, 1'b1, 1'b0, p, w);
      if (p) begin
        e = sb.pop_front();
        n_cmp++; if (w !== e) begin n_fail++; $display("FAIL drain_pop got %h exp %h", w, e); end
      end
    end
    n_cmp++; if (issue_valid !== 1'b0 || sb.size() != 0) begin
      n_fail++; $display("FAIL drain_done got valid %b left %0d exp 0 0", issue_valid, sb.size()); end
  endtask

  task automatic test_back_to_back();
    logic p; logic [62:0] w, e;
    for (int i = 0; i < 3; i++) cyc(1'b1, 3'b010, 30'(100 + i), 30'h3FFF_FFF0, 1'b0, 1'b0, p, w);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 3'(i % 5), 30'(200 + i), 30'(i * 3), 1'b1, 1'b0, p, w);
      if (p) begin
        e = sb.pop_front();
        n_cmp++; if (w !== e) begin n_fail++; $display("FAIL b2b_pop got %h exp %h", w, e); end
      end
      n_cmp++; if (level !== 4'd3) begin n_fail++; $display("FAIL b2b_level got %0d exp 3", level); end
    end
    for (int k = 0; k < 6 && sb.size() != 0; k++) begin
      cyc(1'b0, 3'b000, 30'd0, 30'd0, 1'b1, 1'b0, p, w);
      if (p) begin
        e = sb.pop_front();
        n_cmp++; if (w !== e) begin n_fail++; $display("FAIL b2b_drain got %h exp %h", w, e); end
      end
    end
  endtask

  task automatic test_reject();
    logic p; logic [62:0] w, e;
    cyc(1'b1, 3'b101, 30'd9, 30'd9, 1'b0, 1'b0, p, w);
    n_cmp++; if (reject_pulse !== exp_pulse) begin n_fail++; $display("FAIL rej_pulse1 got %b exp %b", reject_pulse, exp_pulse); end
    cyc(1'b1, 3'b111, 30'd9, 30'd9, 1'b0, 1'b0, p, w);
    n_cmp++; if (reject_pulse !== exp_pulse) begin n_fail++; $display("FAIL rej_pulse2 got %b exp %b", reject_pulse, exp_pulse); end
    cyc(1'b1, 3'b000, 30'd1, 30'd2, 1'b0, 1'b0, p, w);
    n_cmp++; if (reject_pulse !== 1'b0) begin n_fail++; $display("FAIL rej_pulse3 got %b exp 0", reject_pulse); end
    n_cmp++; if (reject_cnt !== exp_rej) begin n_fail++; $display("FAIL rej_cnt got %h exp %h", reject_cnt, exp_rej); end
    n_cmp++; if (level !== 4'd1) begin n_fail++; $display("FAIL rej_level got %0d exp 1", level); end
    n_cmp++; if (issue_cmd !== {3'b000, 30'd1, 30'd2}) begin
      n_fail++; $display("FAIL rej_cmd got %h exp %h", issue_cmd, {3'b000, 30'd1, 30'd2}); end
    cyc(1'b0, 3'b000, 30'd0, 30'd0, 1'b1, 1'b0, p, w);
    if (p) begin
      e = sb.pop_front();
      n_cmp++; if (w !== e) begin n_fail++; $display("FAIL rej_pop got %h exp %h", w, e); end
    end
  endtask

  task automatic test_flush();
    logic p; logic [62:0] w;
    for (int i = 0; i < 5; i++) cyc(1'b1, 3'b011, 30'(300 + i), 30'd1, 1'b0, 1'b0, p, w);
    n_cmp++; if (level !== 4'd5) begin n_fail++; $display("FAIL flush_pre got %0d exp 5", level); end
    cyc(1'b1, 3'b001, 30'd77, 30'd77, 1'b1, 1'b1, p, w);
    n_cmp++; if (level !== 4'd0) begin n_fail++; $display("FAIL flush_level got %0d exp 0", level); end
    n_cmp++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b exp 0", issue_valid); end
    n_cmp++; if (reject_cnt !== exp_rej) begin n_fail++; $display("FAIL flush_cnt got %h exp %h", reject_cnt, exp_rej); end
    cyc(1'b1, 3'b110, 30'd0, 30'd0, 1'b0, 1'b1, p, w);
    n_cmp++; if (reject_pulse !== 1'b0 || reject_cnt !== exp_rej) begin
      n_fail++; $display("FAIL flush_rej got %b/%h exp 0/%h", reject_pulse, reject_cnt, exp_rej); end
    cyc(1'b1, 3'b100, 30'd11, 30'd22, 1'b0, 1'b0, p, w);
    n_cmp++; if (issue_cmd !== sb[0]) begin n_fail++; $display("FAIL flush_after got %h exp %h", issue_cmd, sb[0]); end
    cyc(1'b0, 3'b000, 30'd0, 30'd0, 1'b1, 1'b0, p, w);
    if (p) void'(sb.pop_front());
  endtask

  task automatic test_saturate();
    logic p; logic [62:0] w;
    for (int i = 0; i < 65535; i++) cyc(1'b1, 3'b111, 30'd0, 30'd0, 1'b0, 1'b0, p, w);
    n_cmp++; if (reject_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_cnt got %h exp ffff", reject_cnt); end
    cyc(1'b1, 3'b101, 30'd0, 30'd0, 1'b0, 1'b0, p, w);
    n_cmp++; if (reject_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold got %h exp ffff", reject_cnt); end
    n_cmp++; if (reject_pulse !== 1'b1) begin n_fail++; $display("FAIL sat_pulse got %b exp 1", reject_pulse); end
  endtask

  task automatic test_async_reset();
    logic p; logic [62:0] w;
    for (int i = 0; i < 3; i++) cyc(1'b1, 3'b010, 30'(400 + i), 30'd5, 1'b0, 1'b0, p, w);
    cyc(1'b1, 3'b111, 30'd0, 30'd0, 1'b0, 1'b0, p, w);
    cmd_valid = 1'b1; cmd_tag = 3'b001;
    #2 system1000_rstn = 1'b0;
    #1;
    n_cmp++; if (level !== 4'd0 || issue_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL arst_occ got %0d/%b/%b exp 0/0/1", level, issue_valid, cmd_ready); end
    n_cmp++; if (issue_cmd !== 63'd0 || reject_cnt !== 16'd0 || reject_pulse !== 1'b0) begin
      n_fail++; $display("FAIL arst_out got %h/%h/%b exp 0/0/0", issue_cmd, reject_cnt, reject_pulse); end
    sb.delete(); exp_rej = 16'd0;
    cmd_valid = 1'b0;
    @(negedge system1000);
    system1000_rstn = 1'b1;
  endtask

  initial begin
    system1000_rstn = 1'b0;
    flush = 1'b0; cmd_valid = 1'b0; issue_ready = 1'b0;
    cmd_tag = '0; cmd_a = '0; cmd_b = '0;
    exp_rej = 16'd0; exp_pulse = 1'b0;
    repeat (2) @(negedge system1000);
    system1000_rstn = 1'b1;
    test_reset();
    test_single();
    test_fill_wrap();
    test_back_to_back();
    test_reject();
    test_flush();
    test_saturate();
    test_async_reset();
    test_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
